class_fifo_arb: RTL and testbench
=================================

Name: class_fifo_arb

Overview:
- Consumes the four class-separated streams produced by the class demultiplexer (data_out0..3 and valid_0..3) and buffers each in its own FIFO.
- Drains the four FIFOs through a single registered output port, arbitrating round-robin and tagging each word with its class.
- Sits directly downstream of the demux and upstream of the shared egress/consumer logic.

Parameters:
- DATA_W, 12, word width; matches the demux data_out width.
- DEPTH, 4, entries per class FIFO; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in0..data_in3  in  DATA_W each  per-class data from the demux.
- valid_0..valid_3  in  1 each  write strobe for the matching data_inN.
- pop  in  1  downstream accepts data_out this cycle.
- data_out  out  DATA_W  registered output word.
- class_out  out  2  class index (0..3) of data_out.
- valid_out  out  1  data_out/class_out hold a valid word.
- full  out  4  bit N = FIFO N holds DEPTH entries.
- empty  out  4  bit N = FIFO N holds 0 entries.
- overflow  out  4  bit N is sticky; set when a valid_N write is dropped.

Behaviour:

Reset (reset_L low, asynchronous):
- All FIFO pointers and counts = 0.
- data_out = 0, class_out = 0, valid_out = 0.
- full = 4'b0000, empty = 4'b1111, overflow = 4'b0000.
- Round-robin pointer rr = 0.
- Reset mid-operation discards all buffered words, including the word held in the output register.

Write side (per FIFO N, independent):
- On a rising edge with valid_N = 1, data_inN is written if count_N < DEPTH.
- If FIFO N is full but is being read on the same edge, the write is still accepted; count is unchanged.
- Otherwise a write to a full FIFO is dropped, overflow[N] is set, and stored data is unchanged.
- overflow[N] clears only on reset.

Output register:
- A load slot exists when valid_out = 0 or pop = 1.
- With a load slot and at least one non-empty FIFO:
  - Select the first non-empty FIFO scanning rr, rr+1, ... mod 4.
  - On the edge: data_out <= head word, class_out <= index, valid_out <= 1, pop that FIFO, rr <= index+1 mod 4.
- With a load slot and all FIFOs empty: valid_out <= 0 on the edge. data_out and class_out hold their values (don't-care).
- With valid_out = 1 and pop = 0: output is held stable and no FIFO is read.
- pop while valid_out = 0 is ignored.
- Emptiness is sampled before the edge. A word written on edge E becomes selectable only after E, so it appears on data_out after edge E+1 at the earliest (2-cycle input-to-output latency).

Status and arithmetic:
- full and empty are combinational from the counts, which are PTR_W+1 bits wide.
- Read and write pointers wrap modulo DEPTH.
- A simultaneous read and write on the same FIFO leaves its count unchanged.
- Sustained throughput is one word per cycle while pop = 1 and any FIFO is non-empty.
- Fairness: with all four FIFOs continuously non-empty, output classes cycle 0,1,2,3,0,...

Test Plan:
- Reset then idle: valid_out = 0, empty = 1111, full = 0000, overflow = 0000; reset_L asserted mid-burst clears all of these asynchronously, before the next clk edge.
- Single word: valid_2 = 1, data_in2 = 12'hA5C for one cycle, pop = 1 -> two edges later data_out = 12'hA5C, class_out = 2, valid_out = 1; on the following edge valid_out = 0.
- Round-robin: preload each FIFO N with 12'h100+N and 12'h200+N, then pop = 1 -> output sequence 100,101,102,103,200,201,202,203 with class_out 0,1,2,3,0,1,2,3; no bubbles.
- Backpressure: valid_out = 1 with data 12'h3F0 and pop = 0 for 5 cycles -> data_out stays 12'h3F0 and FIFO counts are unchanged; pop = 1 -> next word follows on the next edge.
- Overflow: pop = 0, write 6 words (12'h001..12'h006) on valid_0.
  - 12'h001 loads the output register and 12'h002..12'h005 fill the FIFO, so full[0] = 1.
  - The 6th write is dropped and overflow[0] = 1.
  - Draining yields 001..005 only; overflow[0] stays 1.
- Simultaneous read and write on full FIFO 1 with pop = 1 -> write accepted, full[1] stays 1, overflow[1] stays 0, order preserved.

Source files
------------

// File: rtl/class_fifo_arb.sv
// Four per-class FIFOs fed by the class demux, drained round-robin through one
// registered output port that tags each word with its class index.
module class_fifo_arb #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              valid_0,
    input  logic              valid_1,
    input  logic              valid_2,
    input  logic              valid_3,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        class_out,
    output logic              valid_out,
    output logic [3:0]        full,
    output logic [3:0]        empty,
    output logic [3:0]        overflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem   [4][DEPTH];
    logic [PTR_W-1:0]  r_wrPtr [4];
    logic [PTR_W-1:0]  r_rdPtr [4];
    logic [PTR_W:0]    r_count [4];
    logic [1:0]        r_rr;

    logic [DATA_W-1:0] w_dataIn [4];
    logic [3:0]        w_validIn;
    logic [3:0]        w_rd;
    logic [3:0]        w_wr;
    logic [3:0]        w_drop;
    logic [1:0]        w_sel;
    logic [1:0]        w_idx;
    logic              w_selValid;
    logic              w_loadSlot;

    assign w_dataIn[0] = data_in0;
    assign w_dataIn[1] = data_in1;
    assign w_dataIn[2] = data_in2;
    assign w_dataIn[3] = data_in3;
    assign w_validIn   = {valid_3, valid_2, valid_1, valid_0};

    for (genvar n = 0; n < 4; n++) begin : g_status
        assign full[n]  = (r_count[n] == FULL_CNT);
        assign empty[n] = (r_count[n] == '0);
    end

    assign w_loadSlot = !valid_out || pop;

    // Walking the offsets downward leaves the nearest non-empty FIFO after rr selected.
    always_comb begin
        w_sel      = '0;
        w_idx      = '0;
        w_selValid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_rr + 2'(i);
            if (!empty[w_idx]) begin
                w_sel      = w_idx;
                w_selValid = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_loadSlot && w_selValid) begin
            w_rd[w_sel] = 1'b1;
        end
        w_wr   = w_validIn & (~full | w_rd);
        w_drop = w_validIn & ~w_wr;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int n = 0; n < 4; n++) begin
                r_wrPtr[n] <= '0;
                r_rdPtr[n] <= '0;
                r_count[n] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_wr[n]) begin
                    r_wrPtr[n] <= r_wrPtr[n] + 1'b1;
                end
                if (w_rd[n]) begin
                    r_rdPtr[n] <= r_rdPtr[n] + 1'b1;
                end
                case ({w_wr[n], w_rd[n]})
                    2'b10:   r_count[n] <= r_count[n] + 1'b1;
                    2'b01:   r_count[n] <= r_count[n] - 1'b1;
                    default: r_count[n] <= r_count[n];
                endcase
            end
            overflow <= overflow | w_drop;
        end
    end

    // A write into a full FIFO lands in the slot being read this edge; the read sees the old word.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (w_wr[n]) begin
                r_mem[n][r_wrPtr[n]] <= w_dataIn[n];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            class_out <= '0;
            valid_out <= 1'b0;
            r_rr      <= '0;
        end else if (w_loadSlot) begin
            if (w_selValid) begin
                data_out  <= r_mem[w_sel][r_rdPtr[w_sel]];
                class_out <= w_sel;
                valid_out <= 1'b1;
                r_rr      <= w_sel + 2'd1;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_class_fifo_arb.sv
// Directed bench for class_fifo_arb: a vector table for the main flows plus
// hand-written sequences for async reset, backpressure and full-FIFO read/write.
module tb_class_fifo_arb;

    logic        clk;
    logic        reset_L;
    logic [11:0] data_in0, data_in1, data_in2, data_in3;
    logic        valid_0, valid_1, valid_2, valid_3;
    logic        pop;
    logic [11:0] data_out;
    logic [1:0]  class_out;
    logic        valid_out;
    logic [3:0]  full, empty, overflow;

    int compareCount = 0;
    int failCount    = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [11:0] d0, d1, d2, d3;
        logic        pop;
        logic        eVo;
        logic [11:0] eData;
        logic [1:0]  eCls;
        logic [3:0]  eFull;
        logic [3:0]  eEmpty;
        logic [3:0]  eOvf;
    } vec_t;

    vec_t vecs[$];

    class_fifo_arb #(.DATA_W(12), .DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .valid_0   (valid_0),
        .valid_1   (valid_1),
        .valid_2   (valid_2),
        .valid_3   (valid_3),
        .pop       (pop),
        .data_out  (data_out),
        .class_out (class_out),
        .valid_out (valid_out),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic rst, logic [3:0] vld, logic [11:0] d0, logic [11:0] d1,
                                   logic [11:0] d2, logic [11:0] d3, logic p, logic eVo,
                                   logic [11:0] eData, logic [1:0] eCls, logic [3:0] eFull,
                                   logic [3:0] eEmpty, logic [3:0] eOvf);
        vec_t v;
        v.rst = rst; v.vld = vld; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.pop = p;
        v.eVo = eVo; v.eData = eData; v.eCls = eCls;
        v.eFull = eFull; v.eEmpty = eEmpty; v.eOvf = eOvf;
        return v;
    endfunction

    task automatic drive(input logic [3:0] vld, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d, input logic p);
        {valid_3, valid_2, valid_1, valid_0} = vld;
        data_in0 = a; data_in1 = b; data_in2 = c; data_in3 = d;
        pop = p;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.vld, v.d0, v.d1, v.d2, v.d3, v.pop);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_L = 1'b0;
        drive(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        #2;
        reset_L = 1'b1;
    endtask

    task automatic stepCycle(input logic [3:0] vld, input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input logic [11:0] d, input logic p);
        @(negedge clk);
        drive(vld, a, b, c, d, p);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L = 1'b0;
        drive(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        #12;
        checkOutput("rst valid_out", 16'(valid_out), 16'h0);
        checkOutput("rst data_out",  16'(data_out),  16'h0);
        checkOutput("rst class_out", 16'(class_out), 16'h0);
        checkOutput("rst empty",     16'(empty),     16'hF);
        checkOutput("rst full",      16'(full),      16'h0);
        checkOutput("rst overflow",  16'(overflow),  16'h0);

        // Single word through FIFO 2
        vecs.push_back(mkVec(1, 4'b0100, 12'h0, 12'h0, 12'hA5C, 12'h0, 1, 0, 12'h000, 0, 4'h0, 4'b1011, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0,   12'h0, 1, 1, 12'hA5C, 2, 4'h0, 4'b1111, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0,   12'h0, 1, 0, 12'h000, 0, 4'h0, 4'b1111, 4'h0));
        // Round-robin across four preloaded FIFOs
        vecs.push_back(mkVec(1, 4'b1111, 12'h100, 12'h101, 12'h102, 12'h103, 0, 0, 12'h000, 0, 4'h0, 4'b0000, 4'h0));
        vecs.push_back(mkVec(0, 4'b1111, 12'h200, 12'h201, 12'h202, 12'h203, 0, 1, 12'h100, 0, 4'h0, 4'b0000, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h101, 1, 4'h0, 4'b0000, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h102, 2, 4'h0, 4'b0000, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h103, 3, 4'h0, 4'b0000, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h200, 0, 4'h0, 4'b0001, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h201, 1, 4'h0, 4'b0011, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h202, 2, 4'h0, 4'b0111, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h203, 3, 4'h0, 4'b1111, 4'h0));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 0, 12'h000, 0, 4'h0, 4'b1111, 4'h0));
        // Overflow on FIFO 0 with the output stalled
        vecs.push_back(mkVec(1, 4'b0001, 12'h001, 12'h0, 12'h0, 12'h0, 0, 0, 12'h000, 0, 4'h0, 4'b1110, 4'h0));
        vecs.push_back(mkVec(0, 4'b0001, 12'h002, 12'h0, 12'h0, 12'h0, 0, 1, 12'h001, 0, 4'h0, 4'b1110, 4'h0));
        vecs.push_back(mkVec(0, 4'b0001, 12'h003, 12'h0, 12'h0, 12'h0, 0, 1, 12'h001, 0, 4'h0, 4'b1110, 4'h0));
        vecs.push_back(mkVec(0, 4'b0001, 12'h004, 12'h0, 12'h0, 12'h0, 0, 1, 12'h001, 0, 4'h0, 4'b1110, 4'h0));
        vecs.push_back(mkVec(0, 4'b0001, 12'h005, 12'h0, 12'h0, 12'h0, 0, 1, 12'h001, 0, 4'h1, 4'b1110, 4'h0));
        vecs.push_back(mkVec(0, 4'b0001, 12'h006, 12'h0, 12'h0, 12'h0, 0, 1, 12'h001, 0, 4'h1, 4'b1110, 4'h1));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h002, 0, 4'h0, 4'b1110, 4'h1));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h003, 0, 4'h0, 4'b1110, 4'h1));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h004, 0, 4'h0, 4'b1110, 4'h1));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 1, 12'h005, 0, 4'h0, 4'b1111, 4'h1));
        vecs.push_back(mkVec(0, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1, 0, 12'h000, 0, 4'h0, 4'b1111, 4'h1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            else @(negedge clk);
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d valid_out", i), 16'(valid_out), 16'(vecs[i].eVo));
            if (vecs[i].eVo) begin
                checkOutput($sformatf("vec%0d data_out", i),  16'(data_out),  16'(vecs[i].eData));
                checkOutput($sformatf("vec%0d class_out", i), 16'(class_out), 16'(vecs[i].eCls));
            end
            checkOutput($sformatf("vec%0d full", i),     16'(full),     16'(vecs[i].eFull));
            checkOutput($sformatf("vec%0d empty", i),    16'(empty),    16'(vecs[i].eEmpty));
            checkOutput($sformatf("vec%0d overflow", i), 16'(overflow), 16'(vecs[i].eOvf));
        end

        // Asynchronous reset in the middle of a burst, checked before the next edge
        doReset();
        for (int k = 0; k < 6; k++) stepCycle(4'b0001, 12'h0A0 + 12'(k), 12'h0, 12'h0, 12'h0, 1'b0);
        checkOutput("pre-arst overflow", 16'(overflow), 16'h1);
        checkOutput("pre-arst data_out", 16'(data_out), 16'h0A0);
        #2;
        reset_L = 1'b0;
        #1;
        checkOutput("arst valid_out", 16'(valid_out), 16'h0);
        checkOutput("arst data_out",  16'(data_out),  16'h0);
        checkOutput("arst empty",     16'(empty),     16'hF);
        checkOutput("arst full",      16'(full),      16'h0);
        checkOutput("arst overflow",  16'(overflow),  16'h0);
        @(negedge clk);
        reset_L = 1'b1;

        // Backpressure: held word must not move and FIFO 3 must not be read
        doReset();
        stepCycle(4'b1000, 12'h0, 12'h0, 12'h0, 12'h3F0, 1'b0);
        stepCycle(4'b1000, 12'h0, 12'h0, 12'h0, 12'h3F1, 1'b0);
        checkOutput("bp load data", 16'(data_out), 16'h3F0);
        checkOutput("bp load class", 16'(class_out), 16'h3);
        for (int k = 0; k < 5; k++) begin
            stepCycle(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
            checkOutput($sformatf("bp hold%0d data", k),  16'(data_out),  16'h3F0);
            checkOutput($sformatf("bp hold%0d valid", k), 16'(valid_out), 16'h1);
            checkOutput($sformatf("bp hold%0d empty", k), 16'(empty),     16'b0111);
        end
        stepCycle(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
        checkOutput("bp next data",  16'(data_out), 16'h3F1);
        checkOutput("bp next empty", 16'(empty),    16'hF);
        stepCycle(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
        checkOutput("bp drained valid", 16'(valid_out), 16'h0);

        // Simultaneous read and write on a full FIFO 1
        doReset();
        for (int k = 0; k < 5; k++) stepCycle(4'b0010, 12'h0, 12'h011 + 12'(k), 12'h0, 12'h0, 1'b0);
        checkOutput("rw prefill full", 16'(full), 16'b0010);
        checkOutput("rw prefill data", 16'(data_out), 16'h011);
        stepCycle(4'b0010, 12'h0, 12'h016, 12'h0, 12'h0, 1'b1);
        checkOutput("rw data",     16'(data_out),  16'h012);
        checkOutput("rw class",    16'(class_out), 16'h1);
        checkOutput("rw full",     16'(full),      16'b0010);
        checkOutput("rw overflow", 16'(overflow),  16'h0);
        for (int k = 0; k < 4; k++) begin
            stepCycle(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
            checkOutput($sformatf("rw drain%0d data", k), 16'(data_out), 16'h013 + 16'(k));
        end
        checkOutput("rw drain empty", 16'(empty), 16'hF);
        stepCycle(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
        checkOutput("rw end valid", 16'(valid_out), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
